// File: rtl/kyber_pkg.sv
// Shared constants and FSM encoding for the M2 polynomial accumulator slice.
package kyber_pkg;
  localparam int KYBER_Q = 3329;
  localparam int COEF_W  = 16;
  localparam int LANES   = 8;
  localparam int WORDS   = 8;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    RD,
    ADD,
    WR,
    DONE
  } state_t;
endpackage

// File: rtl/mod_add_q.sv
// Combinational 12-bit modular adder: s = (a + b) mod KYBER_Q for a, b < KYBER_Q.
module mod_add_q #(
  parameter int KYBER_Q = kyber_pkg::KYBER_Q
) (
  input  logic [11:0] a,
  input  logic [11:0] b,
  output logic [11:0] s
);

  // Inputs are already reduced, so a single conditional subtraction suffices.
  function automatic logic [11:0] reduce_q(input logic [12:0] v);
    if (v >= 13'(KYBER_Q)) return 12'(v - 13'(KYBER_Q));
    return v[11:0];
  endfunction

  assign s = reduce_q({1'b0, a} + {1'b0, b});

endmodule

// File: rtl/pacc_m2_accumulator.sv
// Accumulates n_eff product polynomials (8 words x 8 lanes) into M2 memory,
// one word per REQ/RD/ADD/WR sequence.
module pacc_m2_accumulator #(
  parameter int KYBER_Q = kyber_pkg::KYBER_Q,
  parameter int LANES   = kyber_pkg::LANES,
  parameter int WORDS   = kyber_pkg::WORDS
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [1:0]                          n_terms,
  input  logic                                prod_valid,
  input  logic [LANES*kyber_pkg::COEF_W-1:0]  prod_data,
  output logic                                prod_ready,
  input  logic [LANES*kyber_pkg::COEF_W-1:0]  M2_RData,
  output logic [2:0]                          P4_M2_RAd,
  output logic                                P4_M2_WEN,
  output logic [7:0]                          P4_M2_WAd,
  output logic [LANES*kyber_pkg::COEF_W-1:0]  P4_M2_WData,
  output logic                                busy,
  output logic                                done
);
  import kyber_pkg::*;

  localparam int         DW       = LANES * COEF_W;
  localparam logic [2:0] LAST_IDX = 3'(WORDS - 1);

  state_t          state, state_nxt;
  logic [2:0]      idx;
  logic [1:0]      term;
  logic [1:0]      n_eff;
  logic [DW-1:0]   prod_p0;
  logic [DW-1:0]   sum_p1;
  logic [DW-1:0]   sum_comb;
  logic [2:0]      rad;
  logic            last_word;
  logic            last_term;

  assign last_word = (idx == LAST_IDX);
  assign last_term = (term == n_eff - 2'd1);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = REQ;
      REQ:     if (prod_valid) state_nxt = RD;
      RD:      state_nxt = ADD;
      ADD:     state_nxt = WR;
      WR:      state_nxt = (last_word && last_term) ? DONE : REQ;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Lane adders: the first term overwrites M2, later terms add to it.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [11:0] b_lane;
    logic [11:0] s_lane;
    logic        lane_unused;

    assign b_lane = (term == 2'd0) ? 12'd0 : M2_RData[i*COEF_W +: 12];
    assign lane_unused = ^{prod_p0[i*COEF_W+12 +: COEF_W-12],
                           M2_RData[i*COEF_W+12 +: COEF_W-12]};

    mod_add_q #(.KYBER_Q(KYBER_Q)) u_add (
      .a (prod_p0[i*COEF_W +: 12]),
      .b (b_lane),
      .s (s_lane)
    );

    assign sum_comb[i*COEF_W +: COEF_W] = {{(COEF_W-12){1'b0}}, s_lane};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      term    <= '0;
      n_eff   <= 2'd1;
      prod_p0 <= '0;
      sum_p1  <= '0;
      rad     <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (start) begin
          idx   <= '0;
          term  <= '0;
          n_eff <= (n_terms == 2'd0) ? 2'd1 : n_terms;
        end
        // Stage p0: capture product word and issue the M2 read.
        REQ: if (prod_valid) begin
          prod_p0 <= prod_data;
          rad     <= idx;
        end
        // Stage p1: M2 data has arrived; register the modular sum.
        ADD: sum_p1 <= sum_comb;
        WR: begin
          if (!last_word) begin
            idx <= idx + 3'd1;
          end else if (!last_term) begin
            idx  <= '0;
            term <= term + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Write enable is gated by rst so an abort in WR never commits the word.
  assign P4_M2_WEN   = (state == WR) && !rst;
  assign P4_M2_WAd   = P4_M2_WEN ? {5'b0, idx} : 8'd0;
  assign P4_M2_WData = P4_M2_WEN ? sum_p1 : '0;
  assign P4_M2_RAd   = rad;
  assign prod_ready  = (state == REQ);
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);

endmodule

// File: tb/tb_pacc_m2_accumulator.sv
// Directed/randomized bench for pacc_m2_accumulator with a BRAM model and a
// modular-sum reference model of the M2 contents.
module tb_pacc_m2_accumulator;

  localparam int Q = 3329;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   n_terms;
  logic         prod_valid;
  logic [127:0] prod_data;
  logic         prod_ready;
  logic [127:0] M2_RData;
  logic [2:0]   P4_M2_RAd;
  logic         P4_M2_WEN;
  logic [7:0]   P4_M2_WAd;
  logic [127:0] P4_M2_WData;
  logic         busy;
  logic         done;

  always #5 clk = ~clk;

  pacc_m2_accumulator dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .n_terms     (n_terms),
    .prod_valid  (prod_valid),
    .prod_data   (prod_data),
    .prod_ready  (prod_ready),
    .M2_RData    (M2_RData),
    .P4_M2_RAd   (P4_M2_RAd),
    .P4_M2_WEN   (P4_M2_WEN),
    .P4_M2_WAd   (P4_M2_WAd),
    .P4_M2_WData (P4_M2_WData),
    .busy        (busy),
    .done        (done)
  );

  // BRAM model: one-cycle registered read, synchronous write.
  logic [127:0] mem [8];
  logic [127:0] rdata_q;
  logic         bram_mode;

  always @(posedge clk) begin
    if (P4_M2_WEN) mem[P4_M2_WAd[2:0]] <= P4_M2_WData;
    rdata_q <= mem[P4_M2_RAd];
  end

  assign M2_RData = bram_mode ? rdata_q : {8{16'h07FF}};

  typedef struct {
    logic [7:0]   wad;
    logic [127:0] data;
  } wr_t;

  logic [127:0] model_mem [8];
  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic run_job(input logic [1:0] nt, input bit use_const, input int cv0,
                         input int cv1, input int vpct, input bit bram,
                         input bit extra_start, input string tag);
    int n_eff, hs, writes, busy_cyc, pending, t, wd, pv, ov;
    bit seen_done;
    wr_t q[$];
    wr_t e;
    logic [127:0] w;
    n_eff = (nt == 2'd0) ? 1 : int'(nt);
    hs = 0; writes = 0; busy_cyc = 0; pending = 0; seen_done = 0;
    bram_mode = bram;
    @(negedge clk);
    n_terms = nt;
    start = 1'b1;
    for (int cyc = 0; cyc < 3000 && !seen_done; cyc++) begin
      @(negedge clk);
      if (cyc == 0) start = 1'b0;
      if (extra_start && cyc == 12) begin
        start = 1'b1;
        n_terms = 2'd3;
      end else if (extra_start && cyc == 13) begin
        start = 1'b0;
      end
      if (busy) busy_cyc++;
      if (P4_M2_WEN) begin
        chk({tag, "_wen_after_hs"}, 128'(pending > 0), 128'd1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk({tag, "_wad"}, 128'(P4_M2_WAd), 128'(e.wad));
          chk({tag, "_wdata"}, P4_M2_WData, e.data);
        end
        pending--;
        writes++;
      end
      if (done) begin
        seen_done = 1'b1;
      end else begin
        prod_valid = ($urandom_range(0, 99) < vpct);
        t = hs / 8;
        for (int l = 0; l < 8; l++) begin
          if (use_const) pv = (t == 0) ? cv0 : cv1;
          else pv = $urandom_range(0, Q - 1);
          prod_data[l*16 +: 16] = 16'(pv);
        end
        if (prod_ready && prod_valid) begin
          wd = hs % 8;
          for (int l = 0; l < 8; l++) begin
            ov = (t == 0) ? 0 : int'(model_mem[wd][l*16 +: 16]);
            w[l*16 +: 16] = 16'((ov + int'(prod_data[l*16 +: 16])) % Q);
          end
          model_mem[wd] = w;
          e.wad = 8'(wd);
          e.data = w;
          q.push_back(e);
          hs++;
          pending++;
        end
      end
    end
    prod_valid = 1'b0;
    chk({tag, "_done_seen"}, 128'(seen_done), 128'd1);
    chk({tag, "_write_count"}, 128'(writes), 128'(8 * n_eff));
    chk({tag, "_hs_count"}, 128'(hs), 128'(8 * n_eff));
    if (vpct == 100) chk({tag, "_cycles"}, 128'(busy_cyc), 128'(32 * n_eff + 1));
    @(negedge clk);
    chk({tag, "_busy_cleared"}, 128'(busy), 128'd0);
    chk({tag, "_done_one_cycle"}, 128'(done), 128'd0);
    for (int i = 0; i < 8; i++) chk({tag, "_mem"}, mem[i], model_mem[i]);
  endtask

  initial begin
    logic [127:0] saved;
    bit found, bad_done, bad_wen;
    rst = 1'b1; start = 1'b0; n_terms = 2'd1; prod_valid = 1'b0;
    prod_data = '0; bram_mode = 1'b1;
    for (int i = 0; i < 8; i++) begin
      mem[i] = {8{16'h07FF}};
      model_mem[i] = {8{16'h07FF}};
    end
    repeat (3) @(negedge clk);
    chk("rst_ready", 128'(prod_ready), 128'd0);
    chk("rst_wen", 128'(P4_M2_WEN), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_rad", 128'(P4_M2_RAd), 128'd0);
    chk("rst_wad", 128'(P4_M2_WAd), 128'd0);
    chk("rst_wdata", P4_M2_WData, 128'd0);
    rst = 1'b0;

    run_job(2'd1, 1'b1, 3328, 0, 100, 1'b0, 1'b0, "max_single");
    for (int i = 0; i < 8; i++) chk("max_single_const", mem[i], {8{16'd3328}});

    run_job(2'd2, 1'b1, 3000, 1000, 100, 1'b1, 1'b0, "wrap671");
    for (int i = 0; i < 8; i++) chk("wrap671_const", mem[i], {8{16'd671}});

    run_job(2'd2, 1'b1, 1664, 1664, 100, 1'b1, 1'b0, "boundary");
    for (int i = 0; i < 8; i++) chk("boundary_const", mem[i], {8{16'd3328}});

    run_job(2'd3, 1'b0, 0, 0, 100, 1'b1, 1'b0, "rand3");
    run_job(2'd2, 1'b0, 0, 0, 40, 1'b1, 1'b0, "stall");
    run_job(2'd0, 1'b0, 0, 0, 100, 1'b1, 1'b1, "nterms0");

    // Abort in the WR cycle of word 3.
    bram_mode = 1'b1;
    @(negedge clk);
    n_terms = 2'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    prod_valid = 1'b1;
    found = 1'b0;
    saved = mem[3];
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clk);
      if (P4_M2_WEN && P4_M2_WAd == 8'd3) found = 1'b1;
    end
    chk("abort_reached_wr3", 128'(found), 128'd1);
    rst = 1'b1;
    #1;
    chk("abort_wen_in_rst_cycle", 128'(P4_M2_WEN), 128'd0);
    @(posedge clk);
    #1;
    chk("abort_ready", 128'(prod_ready), 128'd0);
    chk("abort_wen", 128'(P4_M2_WEN), 128'd0);
    chk("abort_wad", 128'(P4_M2_WAd), 128'd0);
    chk("abort_wdata", P4_M2_WData, 128'd0);
    chk("abort_rad", 128'(P4_M2_RAd), 128'd0);
    chk("abort_busy", 128'(busy), 128'd0);
    chk("abort_done", 128'(done), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    bad_done = 1'b0;
    bad_wen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) bad_done = 1'b1;
      if (P4_M2_WEN) bad_wen = 1'b1;
    end
    prod_valid = 1'b0;
    chk("abort_no_done", 128'(bad_done), 128'd0);
    chk("abort_no_wen", 128'(bad_wen), 128'd0);
    chk("abort_word3_untouched", mem[3], saved);

    run_job(2'd1, 1'b0, 0, 0, 70, 1'b1, 1'b0, "restart");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
